// File: rtl/sdam_burst.sv
`default_nettype none
// ============================================================================
//  Module   : sdam_burst
//  Purpose  : One-wire serial address/data burst deserializer. A frame of
//             start bit(s), a marker, a burst length, a base address and
//             LEN+1 data words (each with an optional even-parity bit) is
//             sampled on posedge scl. One address/data pair is emitted per
//             word, with the address incremented for every word.
//  Ports    : scl    - sampling clock (posedge)
//             reset  - asynchronous, active-high reset
//             sda    - serial data in
//             avalid - one-cycle pulse, aout valid
//             aout   - word address (base + word index, wraps in ADDR_W bits)
//             dvalid - one-cycle pulse, dout valid (coincident with avalid)
//             dout   - received data word
//             perr   - one-cycle pulse, parity error on the current word
//             busy   - FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module sdam_burst #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 2,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              scl,
    input  logic              reset,
    input  logic              sda,
    output logic              avalid,
    output logic [ADDR_W-1:0] aout,
    output logic              dvalid,
    output logic [DATA_W-1:0] dout,
    output logic              perr,
    output logic              busy
);

    localparam int MAX_AL = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int MAX_W  = (DATA_W > MAX_AL) ? DATA_W : MAX_AL;
    localparam int CNT_W  = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MARK = 3'd1,
        S_LEN  = 3'd2,
        S_ADDR = 3'd3,
        S_DATA = 3'd4,
        S_PAR  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   aout_q, aout_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                avalid_q, avalid_d;
    logic                perr_q, perr_d;

    // Shifted field values including the bit on sda this edge. LSB-first
    // fields enter at the top and move down, so after W bits the first bit
    // received sits at bit 0.
    logic [LEN_W-1:0]    len_sh;
    logic [ADDR_W-1:0]   base_sh;
    logic [DATA_W-1:0]   data_sh;

    always_comb begin
        if (MSB_FIRST != 0) begin
            len_sh  = (len_q  << 1) | LEN_W'(sda);
            base_sh = (base_q << 1) | ADDR_W'(sda);
            data_sh = (data_q << 1) | DATA_W'(sda);
        end else begin
            len_sh  = (len_q  >> 1) | (LEN_W'(sda)  << (LEN_W - 1));
            base_sh = (base_q >> 1) | (ADDR_W'(sda) << (ADDR_W - 1));
            data_sh = (data_q >> 1) | (DATA_W'(sda) << (DATA_W - 1));
        end
    end

    logic                word_done;
    logic [DATA_W-1:0]   word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        idx_d     = idx_q;
        base_d    = base_q;
        data_d    = data_q;
        aout_d    = aout_q;
        dout_d    = dout_q;
        avalid_d  = 1'b0;
        perr_d    = 1'b0;
        word_done = 1'b0;
        word      = data_q;

        case (state_q)
            S_IDLE: begin
                if (!sda) begin
                    state_d = S_MARK;
                end
            end
            S_MARK: begin
                // Extra start bits (zeros) are tolerated here.
                if (sda) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                len_d = len_sh;
                if (cnt_q == CNT_W'(LEN_W - 1)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ADDR: begin
                base_d = base_sh;
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                data_d = data_sh;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d = '0;
                    if (PARITY_EN != 0) begin
                        state_d = S_PAR;
                    end else begin
                        word_done = 1'b1;
                        word      = data_sh;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PAR: begin
                if ((^data_q) ^ sda) begin
                    // Bad word: flag it and drop the rest of the burst.
                    perr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    word_done = 1'b1;
                    word      = data_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (word_done) begin
            avalid_d = 1'b1;
            aout_d   = base_q + ADDR_W'(idx_q);
            dout_d   = word;
            if (idx_q == len_q) begin
                state_d = S_IDLE;
            end else begin
                idx_d   = idx_q + LEN_W'(1);
                state_d = S_DATA;
            end
        end
    end

    always_ff @(posedge scl or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            base_q   <= '0;
            data_q   <= '0;
            aout_q   <= '0;
            dout_q   <= '0;
            avalid_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            data_q   <= data_d;
            aout_q   <= aout_d;
            dout_q   <= dout_d;
            avalid_q <= avalid_d;
            perr_q   <= perr_d;
        end
    end

    assign avalid = avalid_q;
    assign dvalid = avalid_q;
    assign aout   = aout_q;
    assign dout   = dout_q;
    assign perr   = perr_q;
    assign busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdam_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdam_burst
//  Purpose  : Self-checking bench for sdam_burst. Instance 0 uses defaults
//             (LSB first, parity on); instance 1 is MSB first, parity off.
//             Frames are built as bit lists with the expected output events
//             attached to the bit positions that should produce them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdam_burst;

    logic        scl = 1'b0;
    logic        reset;
    logic        sda0, sda1;
    logic        av0, dv0, pe0, bz0, av1, dv1, pe1, bz1;
    logic [7:0]  a0, a1;
    logic [15:0] d0, d1;

    always #5 scl = ~scl;

    sdam_burst u_dut0 (
        .scl(scl), .reset(reset), .sda(sda0),
        .avalid(av0), .aout(a0), .dvalid(dv0), .dout(d0), .perr(pe0), .busy(bz0)
    );

    sdam_burst #(.MSB_FIRST(1), .PARITY_EN(0)) u_dut1 (
        .scl(scl), .reset(reset), .sda(sda1),
        .avalid(av1), .aout(a1), .dvalid(dv1), .dout(d1), .perr(pe1), .busy(bz1)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: last emitted address/data per instance.
    logic [7:0]  last_a [2];
    logic [15:0] last_d [2];
    logic [15:0] wd [4];

    // Frame under construction: bit, event (0 none, 1 valid, 2 perr), exp addr/data.
    bit          q_bit [$];
    int          q_ev  [$];
    logic [7:0]  q_a   [$];
    logic [15:0] q_d   [$];

    task automatic put(input bit b, input int e, input logic [7:0] a, input logic [15:0] d);
        q_bit.push_back(b);
        q_ev.push_back(e);
        q_a.push_back(a);
        q_d.push_back(d);
    endtask

    task automatic get(input int sel, output logic av, output logic dv, output logic pe,
                       output logic bz, output logic [7:0] a, output logic [15:0] d);
        if (sel == 0) begin
            av = av0; dv = dv0; pe = pe0; bz = bz0; a = a0; d = d0;
        end else begin
            av = av1; dv = dv1; pe = pe1; bz = bz1; a = a1; d = d1;
        end
    endtask

    task automatic send_frame(input int sel, input int n_start, input int len,
                              input logic [7:0] addr, input int bad_w, input int abort_at);
        bit          msb;
        bit          par;
        logic [1:0]  lv;
        logic [7:0]  ea;
        logic        av, dv, pe, bz;
        logic [7:0]  a;
        logic [15:0] d;
        int          last;
        msb = (sel == 1);
        par = (sel == 0);
        lv  = len[1:0];
        q_bit.delete(); q_ev.delete(); q_a.delete(); q_d.delete();

        for (int i = 0; i < n_start; i++) put(1'b0, 0, 8'h0, 16'h0);
        put(1'b1, 0, 8'h0, 16'h0);
        for (int i = 0; i < 2; i++) put(msb ? lv[1-i] : lv[i], 0, 8'h0, 16'h0);
        for (int i = 0; i < 8; i++) put(msb ? addr[7-i] : addr[i], 0, 8'h0, 16'h0);
        for (int w = 0; w <= len; w++) begin
            ea = addr + 8'(w);
            for (int i = 0; i < 16; i++) begin
                put(msb ? wd[w][15-i] : wd[w][i],
                    (!par && i == 15) ? 1 : 0, ea, wd[w]);
            end
            if (par) begin
                put((^wd[w]) ^ (w == bad_w), (w == bad_w) ? 2 : 1, ea, wd[w]);
                if (w == bad_w) break;
            end
        end

        last = q_bit.size() - 1;
        for (int k = 0; k <= last; k++) begin
            if (k == abort_at) begin
                @(negedge scl);
                reset = 1'b1;
                #1;
                chk("abort_av0", {31'b0, av0}, 32'h0);
                chk("abort_busy0", {31'b0, bz0}, 32'h0);
                chk("abort_aout0", {24'b0, a0}, 32'h0);
                chk("abort_dout0", {16'b0, d0}, 32'h0);
                chk("abort_busy1", {31'b0, bz1}, 32'h0);
                last_a[0] = 8'h0; last_d[0] = 16'h0;
                last_a[1] = 8'h0; last_d[1] = 16'h0;
                @(posedge scl);
                @(negedge scl);
                reset = 1'b0;
                break;
            end
            @(negedge scl);
            if (sel == 0) sda0 = q_bit[k]; else sda1 = q_bit[k];
            @(posedge scl);
            #1;
            get(sel, av, dv, pe, bz, a, d);
            if (q_ev[k] == 1) begin
                last_a[sel] = q_a[k];
                last_d[sel] = q_d[k];
            end
            chk("avalid", {31'b0, av}, {31'b0, q_ev[k] == 1});
            chk("dvalid", {31'b0, dv}, {31'b0, q_ev[k] == 1});
            chk("perr",   {31'b0, pe}, {31'b0, q_ev[k] == 2});
            chk("aout",   {24'b0, a},  {24'b0, last_a[sel]});
            chk("dout",   {16'b0, d},  {16'b0, last_d[sel]});
            if (k != last) chk("busy", {31'b0, bz}, 32'h1);
        end
        sda0 = 1'b1;
        sda1 = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge scl);
            sda0 = 1'b1;
            sda1 = 1'b1;
            @(posedge scl);
            #1;
            chk("idle_av0", {31'b0, av0}, 32'h0);
            chk("idle_pe0", {31'b0, pe0}, 32'h0);
            chk("idle_busy0", {31'b0, bz0}, 32'h0);
            chk("idle_av1", {31'b0, av1}, 32'h0);
            chk("idle_busy1", {31'b0, bz1}, 32'h0);
            chk("idle_aout0", {24'b0, a0}, {24'b0, last_a[0]});
            chk("idle_dout1", {16'b0, d1}, {16'b0, last_d[1]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sel, len, bad;
        reset = 1'b1;
        sda0  = 1'b1;
        sda1  = 1'b1;
        last_a[0] = 8'h0; last_d[0] = 16'h0;
        last_a[1] = 8'h0; last_d[1] = 16'h0;
        #1;
        chk("rst_av0", {31'b0, av0}, 32'h0);
        chk("rst_dv0", {31'b0, dv0}, 32'h0);
        chk("rst_pe0", {31'b0, pe0}, 32'h0);
        chk("rst_busy0", {31'b0, bz0}, 32'h0);
        chk("rst_aout0", {24'b0, a0}, 32'h0);
        chk("rst_dout0", {16'b0, d0}, 32'h0);
        chk("rst_av1", {31'b0, av1}, 32'h0);
        repeat (2) @(posedge scl);
        @(negedge scl);
        reset = 1'b0;
        idle(1);

        // Single word, defaults.
        wd[0] = 16'h1234;
        send_frame(0, 1, 0, 8'h5A, -1, -1);
        idle(1);

        // Three words with address wrap.
        wd[0] = 16'h0001; wd[1] = 16'h8000; wd[2] = 16'hFFFF;
        send_frame(0, 1, 2, 8'hFF, -1, -1);
        idle(1);

        // Parity error on word 1 abandons the burst.
        wd[0] = 16'hAAAA; wd[1] = 16'h5555; wd[2] = 16'h0F0F; wd[3] = 16'h1111;
        send_frame(0, 2, 3, 8'h10, 1, -1);
        idle(2);

        // Reset mid-ADDR, then a clean frame.
        wd[0] = 16'h9999;
        send_frame(0, 1, 0, 8'h77, -1, 7);
        wd[0] = 16'hBEEF;
        send_frame(0, 1, 0, 8'h33, -1, -1);
        idle(1);

        // Back-to-back frames, no idle bits between.
        wd[0] = 16'h4242;
        send_frame(0, 1, 0, 8'h40, -1, -1);
        wd[0] = 16'h2424;
        send_frame(0, 1, 0, 8'h41, -1, -1);
        idle(1);

        // MSB first, no parity.
        wd[0] = 16'hC003;
        send_frame(1, 1, 0, 8'hA0, -1, -1);
        idle(1);

        // Randomized frames on both instances.
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 1));
            len = int'($urandom_range(0, 3));
            for (int w = 0; w < 4; w++) wd[w] = 16'($urandom);
            bad = (sel == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
            send_frame(sel, int'($urandom_range(1, 3)), len, 8'($urandom), bad, -1);
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
